pi_bus_master: RTL and testbench



---
 rtl/pi_bus_pkg.sv | 21 ++
 rtl/sync_bit.sv | 31 +++
 rtl/pi_bus_master.sv | 163 ++++++++++++++++
 tb/tb_pi_bus_master.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_bus_pkg.sv
// Shared definitions for the Raspberry Pi bus path (bridge, timing generator, bus master).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   PI_ADDR_WIDTH  - width of the Pi memory address
//   PI_DATA_WIDTH  - width of a Pi data byte
//   pi_bus_state_t - bus master FSM states
package pi_bus_pkg;

    localparam int PI_ADDR_WIDTH = 17;
    localparam int PI_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SLOT = 2'd1,
        ACCESS    = 2'd2,
        COMPLETE  = 2'd3
    } pi_bus_state_t;

endpackage : pi_bus_pkg

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer for a level or toggle crossing into clk.
// Latency: STAGES clk edges from d_i change to q_o change.
// Backpressure: none; the input is sampled every cycle.
//
// Ports:
//   clk     - destination clock
//   reset_n - synchronous active-low reset, clears every stage to 0
//   d_i     - asynchronous input bit
//   q_o     - synchronized output (last stage)
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : sync_bit

// File: rtl/pi_bus_master.sv
// Carries one Pi read/write request from the SPI bridge onto the memory bus in a free slot.
// Latency: accept at first slot once visible; bus_en for ACCESS_CYCLES; pi_done toggles ACCESS_CYCLES+1 edges after accept.
// Backpressure: requests wait in WAIT_SLOT until pi_slot; one request in flight, bridge holds off until pi_done follows.
//
// Ports:
//   clk, reset_n                 - system clock, synchronous active-low reset
//   pi_addr, pi_data_out, pi_rw_b - request fields from the bridge (stable while outstanding)
//   pi_pending / pi_done          - request toggle in (async) / completion toggle out
//   pi_data_in                    - read data back to the bridge
//   pi_slot                       - free-slot strobe from the timing generator
//   bus_addr, bus_data_out, bus_data_in, bus_we, bus_en - memory bus
//   busy                          - request accepted and not yet completed
module pi_bus_master
    import pi_bus_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [PI_ADDR_WIDTH-1:0] pi_addr,
    input  logic [PI_DATA_WIDTH-1:0] pi_data_out,
    input  logic                     pi_rw_b,
    input  logic                     pi_pending,
    output logic                     pi_done,
    output logic [PI_DATA_WIDTH-1:0] pi_data_in,
    input  logic                     pi_slot,
    output logic [PI_ADDR_WIDTH-1:0] bus_addr,
    output logic [PI_DATA_WIDTH-1:0] bus_data_out,
    input  logic [PI_DATA_WIDTH-1:0] bus_data_in,
    output logic                     bus_we,
    output logic                     bus_en,
    output logic                     busy
);

    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Request toggle crossing
    // ------------------------------------------------------------------
    logic pending_sync;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_pending_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (pi_pending),
        .q_o     (pending_sync)
    );

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    pi_bus_state_t            state_q,   state_d;
    logic [CNT_W-1:0]         cnt_q,     cnt_d;
    logic                     done_q,    done_d;
    logic [PI_DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [PI_ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [PI_DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic                     we_q,      we_d;
    logic                     en_q,      en_d;
    logic                     busy_q,    busy_d;

    // A request is outstanding while the synchronized toggle disagrees with
    // the completion toggle we last returned.
    logic req_outstanding;
    assign req_outstanding = (pending_sync != done_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        en_d    = en_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE, WAIT_SLOT: begin
                if (req_outstanding) begin
                    if (pi_slot) begin
                        // Accept edge: request fields are sampled only here.
                        state_d = ACCESS;
                        addr_d  = pi_addr;
                        wdata_d = pi_data_out;
                        we_d    = ~pi_rw_b;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = WAIT_SLOT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    // Edge ending the last bus cycle: drop the bus and, for a
                    // read, capture the memory data so it is valid before
                    // pi_done toggles.
                    state_d = COMPLETE;
                    en_d    = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        rdata_d = bus_data_in;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            COMPLETE: begin
                state_d = IDLE;
                done_d  = ~done_q;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign pi_done      = done_q;
    assign pi_data_in   = rdata_q;
    assign bus_addr     = addr_q;
    assign bus_data_out = wdata_q;
    assign bus_we       = we_q;
    assign bus_en       = en_q;
    assign busy         = busy_q;

endmodule : pi_bus_master

// File: tb/tb_pi_bus_master.sv
// Self-checking bench for pi_bus_master with a scoreboard of expected bus accesses.
// Latency: n/a.
// Backpressure: n/a.
module tb_pi_bus_master;

    localparam int AC = 2;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [16:0] pi_addr;
    logic [7:0]  pi_data_out;
    logic        pi_rw_b;
    logic        pi_pending;
    logic        pi_done;
    logic [7:0]  pi_data_in;
    logic        pi_slot;
    logic [16:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;
    logic        bus_we;
    logic        bus_en;
    logic        busy;

    always #5 clk = ~clk;

    pi_bus_master #(
        .SYNC_STAGES   (SS),
        .ACCESS_CYCLES (AC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pi_addr      (pi_addr),
        .pi_data_out  (pi_data_out),
        .pi_rw_b      (pi_rw_b),
        .pi_pending   (pi_pending),
        .pi_done      (pi_done),
        .pi_data_in   (pi_data_in),
        .pi_slot      (pi_slot),
        .bus_addr     (bus_addr),
        .bus_data_out (bus_data_out),
        .bus_data_in  (bus_data_in),
        .bus_we       (bus_we),
        .bus_en       (bus_en),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  wdata;
        logic        we;
        logic [7:0]  rdata;
    } exp_t;

    exp_t exp_q[$];

    // Cycle counter, advanced on every active edge.
    int cyc = 0;
    always @(posedge clk) cyc++;

    // ------------------------------------------------------------------
    // Monitor: pops an expectation at each access start, checks the bus
    // during the access, and checks the completion toggle and read data.
    // ------------------------------------------------------------------
    exp_t        cur;
    bit          cur_vld = 1'b0;
    bit          en_prev = 1'b0;
    int          en_len  = 0;
    int          acc_cyc = 0;
    int          n_acc   = 0;
    logic        done_prev;
    logic [7:0]  din_at_acc;

    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            cur_vld   = 1'b0;
            en_prev   = 1'b0;
            en_len    = 0;
            done_prev = pi_done;
        end else begin
            if (bus_en && !en_prev) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_access", 32'd1, 32'd0);
                end else begin
                    cur        = exp_q.pop_front();
                    cur_vld    = 1'b1;
                    acc_cyc    = cyc;
                    en_len     = 0;
                    din_at_acc = pi_data_in;
                    chk("acc_bus_data_out", bus_data_out, cur.wdata);
                    chk("acc_busy", busy, 1);
                end
            end
            if (bus_en) begin
                en_len++;
                if (cur_vld) begin
                    chk("acc_bus_addr", bus_addr, cur.addr);
                    chk("acc_bus_we", bus_we, cur.we);
                end
            end
            if (!bus_en && en_prev) begin
                chk("en_length", en_len, AC);
                chk("we_after_access", bus_we, 0);
            end
            if (pi_done !== done_prev) begin
                if (!cur_vld) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    chk("done_latency", cyc - acc_cyc, AC + 1);
                    chk("done_data_in", pi_data_in, cur.we ? din_at_acc : cur.rdata);
                    chk("done_busy", busy, 0);
                    cur_vld = 1'b0;
                end
                done_prev = pi_done;
            end
            en_prev = bus_en;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic req(input logic [16:0] a, input logic [7:0] d, input logic rw, input logic [7:0] rd);
        exp_t e;
        @(posedge clk); #1;
        pi_addr     = a;
        pi_data_out = d;
        pi_rw_b     = rw;
        bus_data_in = rd;
        e.addr  = a;
        e.wdata = d;
        e.we    = ~rw;
        e.rdata = rd;
        exp_q.push_back(e);
        pi_pending = ~pi_pending;
    endtask

    task automatic pulse_slot(input int wait_cycles);
        repeat (wait_cycles) @(posedge clk);
        #1 pi_slot = 1'b1;
        @(posedge clk);
        #1 pi_slot = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic d0;
        d0 = pi_done;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pi_done !== d0) break;
        end
        chk(tag, (pi_done !== d0), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic done_orig;
        int   n0;
        bit   bad;

        reset_n     = 1'b0;
        pi_addr     = '0;
        pi_data_out = '0;
        pi_rw_b     = 1'b0;
        pi_pending  = 1'b0;
        pi_slot     = 1'b0;
        bus_data_in = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pi_done", pi_done, 0);
        chk("rst_pi_data_in", pi_data_in, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_data_out", bus_data_out, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_en", bus_en, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Write
        req(17'h15581, 8'h7e, 1'b0, 8'h00);
        pulse_slot(4);
        wait_done("write_done", 20);

        // Read
        req(17'h08000, 8'h11, 1'b1, 8'ha5);
        pulse_slot(3);
        wait_done("read_done", 20);
        chk("read_data_in", pi_data_in, 8'ha5);

        // Slot starvation
        req(17'h1f00f, 8'hc3, 1'b0, 8'h00);
        done_orig = pi_done;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (bus_en !== 1'b0 || busy !== 1'b0 || pi_done !== done_orig) bad = 1'b1;
        end
        chk("starve_quiet", bad, 0);
        pulse_slot(1);
        wait_done("starve_done", 20);

        // Spurious slots: pi_slot held high across the whole access
        done_orig = pi_done;
        n0 = n_acc;
        @(posedge clk); #1 pi_slot = 1'b1;
        req(17'h0c0de, 8'h99, 1'b0, 8'h00);
        wait_done("spur_done1", 20);
        repeat (10) @(negedge clk);
        chk("spur_one_access", n_acc - n0, 1);
        req(17'h00001, 8'h42, 1'b1, 8'h3c);
        wait_done("spur_done2", 20);
        chk("spur_done_restored", pi_done, done_orig);
        chk("spur_two_access", n_acc - n0, 2);
        @(posedge clk); #1 pi_slot = 1'b0;

        // Slot coincident with the first cycle the request is visible
        repeat (2) @(posedge clk);
        req(17'h12345, 8'h0f, 1'b1, 8'h5a);
        @(posedge clk);
        @(posedge clk);
        #1 pi_slot = 1'b1;
        @(posedge clk);
        #1 pi_slot = 1'b0;
        @(negedge clk);
        chk("coincident_accept", bus_en, 1);
        wait_done("coincident_done", 20);

        // Reset mid-access
        req(17'h0abcd, 8'h3c, 1'b0, 8'h00);
        #1 pi_slot = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_en === 1'b1) break;
        end
        chk("rst_mid_started", bus_en, 1);
        #1;
        reset_n = 1'b0;
        pi_slot = 1'b0;
        @(negedge clk);
        chk("rst_mid_pi_done", pi_done, 0);
        chk("rst_mid_pi_data_in", pi_data_in, 0);
        chk("rst_mid_bus_addr", bus_addr, 0);
        chk("rst_mid_bus_data_out", bus_data_out, 0);
        chk("rst_mid_bus_we", bus_we, 0);
        chk("rst_mid_bus_en", bus_en, 0);
        chk("rst_mid_busy", busy, 0);
        begin
            exp_t e;
            e.addr  = 17'h0abcd;
            e.wdata = 8'h3c;
            e.we    = 1'b1;
            e.rdata = 8'h00;
            exp_q.push_back(e);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        pulse_slot(3);
        wait_done("rst_retry_done", 20);
        chk("rst_retry_pi_done", pi_done, 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pi_bus_master
